vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync block. Generates pixel-rate tick, H/V counters, sync pulses with selectable polarity, blanking, and line/frame start strobes for any VESA-style mode. Sits between the board clock and pixel generators / frame-buffer readers. All decoded outputs are cycle-aligned with pixel_x/pixel_y.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 4, clk cycles per pixel (>=1)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
CNT_W, 10, counter width; must hold max(H_TOTAL, V_TOTAL)-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  run/freeze control
pix_tick  output  1  one-clk pixel-rate enable
pixel_x  output  CNT_W  horizontal count 0..H_TOTAL-1
pixel_y  output  CNT_W  vertical count 0..V_TOTAL-1
video_on  output  1  high inside visible region
hsync  output  1  horizontal sync, polarity HSYNC_POL
vsync  output  1  vertical sync, polarity VSYNC_POL
line_start  output  1  one-clk strobe at start of each line
frame_start  output  1  one-clk strobe at start of each frame

Behaviour:
- Reset is clk; reset is asynchronous, active-high. Reset values: divider 0, pixel_x 0, pixel_y 0, video_on 0, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, pix_tick 0.
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Divider: counts 0..CLK_DIV-1, clearing on wrap. pix_tick = enable && div==CLK_DIV-1 (combinational). With CLK_DIV=1, pix_tick = enable.
- On pix_tick: pixel_x increments. At H_TOTAL-1 it wraps to 0 and pixel_y increments. pixel_y wraps to 0 at V_TOTAL-1 on the same tick.
- Decoded outputs are registered from the next-state counter values, so they correspond exactly to the pixel_x/pixel_y presented in the same cycle. Zero latency relative to the counters.
- video_on = x<H_DISPLAY && y<V_DISPLAY.
- hsync is active for H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC.
- vsync is active for V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC.
- line_start = pix_tick && x==0. frame_start = pix_tick && x==0 && y==0. Both mark the final clk of pixel (0,y).
- After reset release, the first clk loads decoded outputs for (0,0) (video_on=1).
- enable low: divider cleared to 0; counters and decoded outputs hold; no strobes. On re-enable, the first pix_tick occurs CLK_DIV clks later.
- Reset mid-frame: immediate return to reset values; counting restarts at (0,0).
- All arithmetic is unsigned CNT_W bits; comparisons use widened constants, with no truncation.

Decomposition:
- Package vga_timing_pkg: localparam sets for 640x480@60 (800x525) and 800x600@60 (1056x628, sync active-high), plus a function computing totals.
- Sub-module clk_en_div (parameter DIV): the divider plus enable, producing pix_tick. The remainder (counters, decode) stays in vga_timing_gen.

Test Plan:
- Defaults, enable=1: pix_tick every 4th clk; pixel_x wraps 799->0 with pixel_y incrementing; pixel_y wraps 524->0; frame period 800*525*4 = 1,680,000 clks.
- Defaults: hsync low exactly for x=656..751, vsync low for y=490..491, video_on high for x<640 && y<480. Check each against pixel_x/pixel_y in the same cycle.
- CLK_DIV=1, 800x600 set, HSYNC_POL=VSYNC_POL=1: pix_tick constant; hsync high for x=840..967; vsync high for y=601..604; line_start every 1056 clks.
- Drop enable at (x=100, y=10) for 50 clks: counters frozen, no pix_tick or strobes. After re-enable, first increment 4 clks later to x=101.
- Assert reset at (x=700, y=300): pixel_x/pixel_y = 0 and hsync/vsync inactive immediately (async). One clk after release, video_on=1 with frame_start on the 4th clk.
- Count frame_start strobes over 3 frames: exactly 3, each coincident with x=0, y=0; line_start count = 3*525.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: shared timing constants for the VGA raster generator.
// Holds the mode parameter sets for 640x480@60 and 800x600@60 plus a
// helper that sums the four segments of a line or frame into its total.
// No ports; imported by the top level and by benches that pick a mode.
package vga_timing_pkg;

  // Total length of a line (or frame) from its four segments.
  function automatic int calcTotal(input int display, input int front,
                                   input int sync, input int back);
    return display + front + sync + back;
  endfunction

  // 640x480@60, 25.175 MHz pixel clock, 800x525 total, negative syncs
  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;
  localparam bit VGA640_HSYNC_POL = 1'b0;
  localparam bit VGA640_VSYNC_POL = 1'b0;
  localparam int VGA640_H_TOTAL   = calcTotal(VGA640_H_DISPLAY, VGA640_H_FRONT,
                                              VGA640_H_SYNC, VGA640_H_BACK);
  localparam int VGA640_V_TOTAL   = calcTotal(VGA640_V_DISPLAY, VGA640_V_FRONT,
                                              VGA640_V_SYNC, VGA640_V_BACK);

  // 800x600@60, 40 MHz pixel clock, 1056x628 total, positive syncs
  localparam int VGA800_H_DISPLAY = 800;
  localparam int VGA800_H_FRONT   = 40;
  localparam int VGA800_H_SYNC    = 128;
  localparam int VGA800_H_BACK    = 88;
  localparam int VGA800_V_DISPLAY = 600;
  localparam int VGA800_V_FRONT   = 1;
  localparam int VGA800_V_SYNC    = 4;
  localparam int VGA800_V_BACK    = 23;
  localparam bit VGA800_HSYNC_POL = 1'b1;
  localparam bit VGA800_VSYNC_POL = 1'b1;
  localparam int VGA800_H_TOTAL   = calcTotal(VGA800_H_DISPLAY, VGA800_H_FRONT,
                                              VGA800_H_SYNC, VGA800_H_BACK);
  localparam int VGA800_V_TOTAL   = calcTotal(VGA800_V_DISPLAY, VGA800_V_FRONT,
                                              VGA800_V_SYNC, VGA800_V_BACK);

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle produced by vga_timing_gen.
// Signals: pix_tick (pixel-rate enable), pixel_x/pixel_y (CNT_W-bit raster
// position), video_on, hsync, vsync, line_start, frame_start.
// Modports: master drives the bundle (timing generator), slave consumes it
// (pixel generators, frame-buffer readers).
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
) ();

  logic             pix_tick;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             video_on;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;

  modport master (
    output pix_tick, pixel_x, pixel_y, video_on, hsync, vsync,
           line_start, frame_start
  );

  modport slave (
    input pix_tick, pixel_x, pixel_y, video_on, hsync, vsync,
          line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// clk_en_div: divides the system clock down to a one-clk pixel-rate enable.
// Ports: clk, reset (async, active-high), enable_i (run/freeze),
// pix_tick_o (high for one clk every DIV clks while enabled).
// Dropping enable_i clears the count, so the first tick after re-enabling
// always lands a full DIV clks later.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic pix_tick_o
);

  // One bit is kept even for DIV=1 so the counter is never zero-width;
  // it then stays at 0 and the tick simply follows enable.
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] divCount_q;
  logic [DIV_W-1:0] divCount_d;
  logic             divWrap;

  assign divWrap    = (divCount_q == DIV_LAST);
  assign pix_tick_o = enable_i && divWrap;

  // Next count: advance while enabled, clear on wrap or when frozen.
  always_comb begin
    divCount_d = divCount_q + DIV_W'(1);
    if (!enable_i || divWrap) begin
      divCount_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCount_q <= '0;
    end else begin
      divCount_q <= divCount_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VESA-style raster timing generator.
// Ports: clk, reset (async, active-high), enable (run/freeze), and the
// vga_timing_gen_if master bundle carrying pix_tick, pixel_x, pixel_y,
// video_on, hsync, vsync, line_start, frame_start.
// video_on/hsync/vsync are registered from the next-state counters so they
// always describe the pixel_x/pixel_y shown in the same cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = calcTotal(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calcTotal(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  // Region limits are held as 32-bit unsigned values and the counters are
  // zero-extended to match, so no limit is ever truncated to CNT_W bits.
  localparam logic [31:0] H_LAST       = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST       = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_DISP_END   = 32'(H_DISPLAY);
  localparam logic [31:0] V_DISP_END   = 32'(V_DISPLAY);
  localparam logic [31:0] H_SYNC_START = 32'(H_DISPLAY + H_FRONT);
  localparam logic [31:0] H_SYNC_END   = 32'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [31:0] V_SYNC_START = 32'(V_DISPLAY + V_FRONT);
  localparam logic [31:0] V_SYNC_END   = 32'(V_DISPLAY + V_FRONT + V_SYNC);

  logic             pixTick;
  logic [CNT_W-1:0] xCount_q, xCount_d;
  logic [CNT_W-1:0] yCount_q, yCount_d;
  logic             videoOn_q, videoOn_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [31:0]      xNow, yNow, xNext, yNext;

  clk_en_div #(
    .DIV(CLK_DIV)
  ) uClkEnDiv (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (enable),
    .pix_tick_o(pixTick)
  );

  assign xNow  = 32'(xCount_q);
  assign yNow  = 32'(yCount_q);
  assign xNext = 32'(xCount_d);
  assign yNext = 32'(yCount_d);

  // Raster position: x steps on each pixel tick, y steps when x wraps,
  // and both wrap together on the last pixel of the frame.
  always_comb begin
    xCount_d = xCount_q;
    yCount_d = yCount_q;
    if (pixTick) begin
      if (xNow == H_LAST) begin
        xCount_d = '0;
        if (yNow == V_LAST) begin
          yCount_d = '0;
        end else begin
          yCount_d = yCount_q + CNT_W'(1);
        end
      end else begin
        xCount_d = xCount_q + CNT_W'(1);
      end
    end
  end

  // Region decode of the position the counters are about to hold, so the
  // registered result lines up with the counters after the edge.
  always_comb begin
    videoOn_d = (xNext < H_DISP_END) && (yNext < V_DISP_END);
    hsync_d   = ((xNext >= H_SYNC_START) && (xNext < H_SYNC_END)) ?
                HSYNC_POL : ~HSYNC_POL;
    vsync_d   = ((yNext >= V_SYNC_START) && (yNext < V_SYNC_END)) ?
                VSYNC_POL : ~VSYNC_POL;
  end

  // Counter and decode registers; reset parks the syncs at their idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xCount_q  <= '0;
      yCount_q  <= '0;
      videoOn_q <= 1'b0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
    end else begin
      xCount_q  <= xCount_d;
      yCount_q  <= yCount_d;
      videoOn_q <= videoOn_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  // Strobes mark the final clk of pixel (0,y), i.e. the tick that leaves it.
  assign vga.pix_tick    = pixTick;
  assign vga.pixel_x     = xCount_q;
  assign vga.pixel_y     = yCount_q;
  assign vga.video_on    = videoOn_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = pixTick && (xCount_q == '0);
  assign vga.frame_start = pixTick && (xCount_q == '0) && (yCount_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen. Three instances share one clock:
// A = default 640x480 mode with CLK_DIV=4, B = 800x600 mode with CLK_DIV=1 and
// positive syncs, C = a tiny 15x11 mode (CLK_DIV=3, hsync active-high) small
// enough to cover vertical wrap and whole frames. A reference model derives
// every output from the number of pixel ticks elapsed and is compared against
// all three instances on every cycle, alongside hand-computed literal checks.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    int tick; int x; int y; int von; int hs; int vs; int ls; int fs;
  } obsT;

  typedef struct {
    int hd; int hf; int hs; int hb; int vd; int vf; int vs; int vb;
    int div; int hpol; int vpol;
  } cfgT;

  logic clk = 1'b0;
  logic rst [3];
  logic en  [3];
  int   checks = 0;
  int   errors = 0;
  int   tickCnt [3];
  int   runLen  [3];
  bit   started [3];
  bit   released = 1'b0;
  bit   doneB = 1'b0;
  bit   doneC = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(10)) ifA ();
  vga_timing_gen_if #(.CNT_W(11)) ifB ();
  vga_timing_gen_if #(.CNT_W(4))  ifC ();

  vga_timing_gen dutA (.clk(clk), .reset(rst[0]), .enable(en[0]), .vga(ifA));

  vga_timing_gen #(
    .H_DISPLAY(VGA800_H_DISPLAY), .H_FRONT(VGA800_H_FRONT),
    .H_SYNC(VGA800_H_SYNC), .H_BACK(VGA800_H_BACK),
    .V_DISPLAY(VGA800_V_DISPLAY), .V_FRONT(VGA800_V_FRONT),
    .V_SYNC(VGA800_V_SYNC), .V_BACK(VGA800_V_BACK),
    .CLK_DIV(1), .HSYNC_POL(VGA800_HSYNC_POL), .VSYNC_POL(VGA800_VSYNC_POL),
    .CNT_W(11)
  ) dutB (.clk(clk), .reset(rst[1]), .enable(en[1]), .vga(ifB));

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(3), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CNT_W(4)
  ) dutC (.clk(clk), .reset(rst[2]), .enable(en[2]), .vga(ifC));

  // Mode table for the model, written out by hand for each instance.
  function automatic cfgT getCfg(input int m);
    cfgT c;
    case (m)
      0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 0, 0};
      1:       c = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 1};
      default: c = '{8, 2, 3, 2, 6, 1, 2, 2, 3, 1, 0};
    endcase
    return c;
  endfunction

  // Expected outputs from ticks elapsed, enabled-run length and reset state.
  function automatic obsT model(input int m, input int tk, input int rn,
                                input bit st, input logic r, input logic e);
    cfgT c;
    obsT o;
    int  ht, vt, hsBeg, vsBeg;
    c  = getCfg(m);
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    hsBeg = c.hd + c.hf;
    vsBeg = c.vd + c.vf;
    o = '{0, 0, 0, 0, 1 - c.hpol, 1 - c.vpol, 0, 0};
    if (r !== 1'b0) return o;
    o.x    = tk % ht;
    o.y    = (tk / ht) % vt;
    o.tick = (e === 1'b1 && (rn % c.div) == c.div - 1) ? 1 : 0;
    if (st) begin
      o.von = (o.x < c.hd && o.y < c.vd) ? 1 : 0;
      o.hs  = (o.x >= hsBeg && o.x < hsBeg + c.hs) ? c.hpol : 1 - c.hpol;
      o.vs  = (o.y >= vsBeg && o.y < vsBeg + c.vs) ? c.vpol : 1 - c.vpol;
    end
    o.ls = (o.tick == 1 && o.x == 0) ? 1 : 0;
    o.fs = (o.ls == 1 && o.y == 0) ? 1 : 0;
    return o;
  endfunction

  function automatic obsT observe(input int m);
    obsT a;
    case (m)
      0: begin
        a.tick = int'(ifA.pix_tick); a.x = int'(ifA.pixel_x); a.y = int'(ifA.pixel_y);
        a.von = int'(ifA.video_on); a.hs = int'(ifA.hsync); a.vs = int'(ifA.vsync);
        a.ls = int'(ifA.line_start); a.fs = int'(ifA.frame_start);
      end
      1: begin
        a.tick = int'(ifB.pix_tick); a.x = int'(ifB.pixel_x); a.y = int'(ifB.pixel_y);
        a.von = int'(ifB.video_on); a.hs = int'(ifB.hsync); a.vs = int'(ifB.vsync);
        a.ls = int'(ifB.line_start); a.fs = int'(ifB.frame_start);
      end
      default: begin
        a.tick = int'(ifC.pix_tick); a.x = int'(ifC.pixel_x); a.y = int'(ifC.pixel_y);
        a.von = int'(ifC.video_on); a.hs = int'(ifC.hsync); a.vs = int'(ifC.vsync);
        a.ls = int'(ifC.line_start); a.fs = int'(ifC.frame_start);
      end
    endcase
    return a;
  endfunction

  // Model state: pixel ticks taken and consecutive enabled clks so far.
  always @(posedge clk) begin
    cfgT c;
    for (int m = 0; m < 3; m++) begin
      c = getCfg(m);
      if (rst[m] !== 1'b0) begin
        tickCnt[m] <= 0;
        runLen[m]  <= 0;
        started[m] <= 1'b0;
      end else begin
        started[m] <= 1'b1;
        if (en[m] === 1'b1) begin
          if ((runLen[m] % c.div) == c.div - 1) tickCnt[m] <= tickCnt[m] + 1;
          runLen[m] <= runLen[m] + 1;
        end else begin
          runLen[m] <= 0;
        end
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    obsT a, e;
    for (int m = 0; m < 3; m++) begin
      a = observe(m);
      e = model(m, tickCnt[m], runLen[m], started[m], rst[m], en[m]);
      checks++;
      if (a != e) begin
        errors++;
        $display("[TB] FAIL cycle_dut%0d t=%0t actual tick=%0d x=%0d y=%0d von=%0d hs=%0d vs=%0d ls=%0d fs=%0d required tick=%0d x=%0d y=%0d von=%0d hs=%0d vs=%0d ls=%0d fs=%0d",
                 m, $time, a.tick, a.x, a.y, a.von, a.hs, a.vs, a.ls, a.fs,
                 e.tick, e.x, e.y, e.von, e.hs, e.vs, e.ls, e.fs);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic r, input logic e);
    rst[m] = r;
    en[m]  = e;
  endtask

  task automatic nextDrive();
    @(posedge clk);
    #2;
  endtask

  task automatic waitPos(input int m, input int wx, input int wy, input int limit,
                         input string name, output bit ok);
    obsT o;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      #1;
      o = observe(m);
      if ((wx < 0 || o.x == wx) && (wy < 0 || o.y == wy)) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout after %0d clks, actual never reached required x=%0d y=%0d",
               name, limit, wx, wy);
    end
  endtask

  // After releasing reset on A with enable high: decode loads on the first
  // clk, and the first pixel tick (a frame start) falls in the 4th clk.
  task automatic releaseChecksA(input string p);
    obsT o;
    @(negedge clk); #1; o = observe(0);
    checkOutput({p, "_von_c1"}, o.von, 0);
    @(negedge clk); #1; o = observe(0);
    checkOutput({p, "_von_c2"}, o.von, 1);
    checkOutput({p, "_fs_c2"}, o.fs, 0);
    @(negedge clk); #1;
    @(negedge clk); #1; o = observe(0);
    checkOutput({p, "_fs_c4"}, o.fs, 1);
    checkOutput({p, "_tick_c4"}, o.tick, 1);
    checkOutput({p, "_x_c4"}, o.x, 0);
  endtask

  // Main sequence, driving instance A through freeze and mid-frame reset.
  initial begin
    obsT o;
    bit  ok;
    int  frozen;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b0);
    repeat (3) nextDrive();
    o = observe(0);
    checkOutput("a_rst_x", o.x, 0);
    checkOutput("a_rst_hs", o.hs, 1);
    checkOutput("a_rst_vs", o.vs, 1);
    checkOutput("a_rst_von", o.von, 0);
    checkOutput("a_rst_tick", o.tick, 0);
    o = observe(1);
    checkOutput("b_rst_hs", o.hs, 0);
    checkOutput("b_rst_vs", o.vs, 0);
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b1);
    released = 1'b1;
    releaseChecksA("a_boot");

    waitPos(0, 100, 10, 40000, "a_wait_100_10", ok);
    nextDrive();
    applyStimulus(0, 1'b0, 1'b0);
    frozen = 0;
    repeat (50) begin
      @(negedge clk); #1; o = observe(0);
      frozen += o.tick + o.ls + o.fs;
    end
    checkOutput("a_frz_x", o.x, 100);
    checkOutput("a_frz_y", o.y, 10);
    checkOutput("a_frz_strobes", frozen, 0);
    nextDrive();
    applyStimulus(0, 1'b0, 1'b1);
    repeat (3) begin @(negedge clk); #1; end
    o = observe(0);
    checkOutput("a_reen_tick_c3", o.tick, 0);
    @(negedge clk); #1; o = observe(0);
    checkOutput("a_reen_tick_c4", o.tick, 1);
    checkOutput("a_reen_x_c4", o.x, 100);
    @(negedge clk); #1; o = observe(0);
    checkOutput("a_reen_x_c5", o.x, 101);

    waitPos(0, 639, 10, 3000, "a_wait_639", ok); o = observe(0);
    checkOutput("a_von_639", o.von, 1);
    waitPos(0, 640, 10, 10, "a_wait_640", ok); o = observe(0);
    checkOutput("a_von_640", o.von, 0);
    waitPos(0, 655, 10, 100, "a_wait_655", ok); o = observe(0);
    checkOutput("a_hs_655", o.hs, 1);
    waitPos(0, 656, 10, 10, "a_wait_656", ok); o = observe(0);
    checkOutput("a_hs_656", o.hs, 0);
    waitPos(0, 751, 10, 400, "a_wait_751", ok); o = observe(0);
    checkOutput("a_hs_751", o.hs, 0);
    waitPos(0, 752, 10, 10, "a_wait_752", ok); o = observe(0);
    checkOutput("a_hs_752", o.hs, 1);

    waitPos(0, 700, 11, 4000, "a_wait_700_11", ok); o = observe(0);
    checkOutput("a_hs_700", o.hs, 0);
    nextDrive();
    applyStimulus(0, 1'b1, 1'b1);
    #1; o = observe(0);
    checkOutput("a_midrst_x", o.x, 0);
    checkOutput("a_midrst_y", o.y, 0);
    checkOutput("a_midrst_hs", o.hs, 1);
    checkOutput("a_midrst_vs", o.vs, 1);
    checkOutput("a_midrst_von", o.von, 0);
    repeat (3) nextDrive();
    applyStimulus(0, 1'b0, 1'b1);
    releaseChecksA("a_rerun");

    repeat (13000) @(negedge clk);
    wait (doneB && doneC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Instance B: line period at CLK_DIV=1 and positive hsync edges.
  initial begin
    obsT o;
    bit  ok;
    int  last, n;
    last = -1;
    n    = 0;
    wait (released);
    for (int i = 1; i <= 3200; i++) begin
      @(negedge clk); #1; o = observe(1);
      if (o.ls == 1) begin
        n++;
        if (last >= 0) checkOutput("b_line_period", i - last, 1056);
        last = i;
      end
    end
    checkOutput("b_line_count", n, 4);
    checkOutput("b_vs_idle", o.vs, 0);
    waitPos(1, 839, -1, 1100, "b_wait_839", ok); o = observe(1);
    checkOutput("b_hs_839", o.hs, 0);
    waitPos(1, 840, -1, 2, "b_wait_840", ok); o = observe(1);
    checkOutput("b_hs_840", o.hs, 1);
    waitPos(1, 967, -1, 200, "b_wait_967", ok); o = observe(1);
    checkOutput("b_hs_967", o.hs, 1);
    waitPos(1, 968, -1, 2, "b_wait_968", ok); o = observe(1);
    checkOutput("b_hs_968", o.hs, 0);
    doneB = 1'b1;
  end

  // Instance C: strobe counts over three whole frames and vertical sync.
  initial begin
    obsT o;
    bit  ok;
    int  fsN, lsN;
    fsN = 0;
    lsN = 0;
    wait (released);
    for (int i = 1; i <= 1485; i++) begin
      @(negedge clk); #1; o = observe(2);
      if (o.ls == 1) lsN++;
      if (o.fs == 1) begin
        fsN++;
        checkOutput("c_fs_x", o.x, 0);
        checkOutput("c_fs_y", o.y, 0);
      end
    end
    checkOutput("c_frame_count", fsN, 3);
    checkOutput("c_line_count", lsN, 33);
    waitPos(2, 0, 6, 600, "c_wait_y6", ok); o = observe(2);
    checkOutput("c_vs_y6", o.vs, 1);
    waitPos(2, 0, 7, 100, "c_wait_y7", ok); o = observe(2);
    checkOutput("c_vs_y7", o.vs, 0);
    waitPos(2, 10, 7, 100, "c_wait_x10", ok); o = observe(2);
    checkOutput("c_hs_x10", o.hs, 1);
    checkOutput("c_von_x10", o.von, 0);
    waitPos(2, 13, 7, 20, "c_wait_x13", ok); o = observe(2);
    checkOutput("c_hs_x13", o.hs, 0);
    waitPos(2, 0, 9, 200, "c_wait_y9", ok); o = observe(2);
    checkOutput("c_vs_y9", o.vs, 1);
    doneC = 1'b1;
  end

endmodule
